// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if
//  Handshake bundle for the sequential radix-4 Booth multiplier.
//  Request side : in_valid / in_ready carrying operands a_i, b_i.
//  Response side: out_valid / out_ready carrying product_o.
//  busy_o reports that the unit holds an operation (computing or waiting).
//  master = operand producer / product consumer, slave = multiplier.
interface booth_seq_ctrl_if #(
  parameter int NUMBIT = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUMBIT-1:0]     a_i;
  logic [NUMBIT-1:0]     b_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*NUMBIT-1:0]   product_o;
  logic                  busy_o;

  modport master (
    output in_valid, a_i, b_i, out_ready,
    input  in_ready, out_valid, product_o, busy_o
  );

  modport slave (
    input  in_valid, a_i, b_i, out_ready,
    output in_ready, out_valid, product_o, busy_o
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl
//  Sequential radix-4 Booth multiplier for unsigned NUMBIT operands.
//  One operand pair is captured in IDLE, then one Booth digit is recoded
//  and its partial product accumulated per cycle for PP_DEEP cycles; the
//  2*NUMBIT product is then held in DONE until the consumer takes it.
// Ports
//  clk    : rising-edge clock
//  rst_n  : synchronous reset, active low
//  bus    : booth_seq_ctrl_if.slave
//           in_valid/in_ready/a_i/b_i     operand handshake (ready only in IDLE)
//           out_valid/out_ready/product_o result handshake (valid only in DONE)
//           busy_o                        high in RUN or DONE
module booth_seq_ctrl #(
  parameter int NUMBIT   = 10,
  parameter int PP_WIDTH = NUMBIT + 1,
  parameter int PP_DEEP  = NUMBIT / 2 + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_seq_ctrl_if.slave   bus
);

  localparam int PW    = 2 * NUMBIT;            // product / accumulator width
  localparam int BW    = NUMBIT + 3;            // recoding register width
  localparam int CNT_W = (PP_DEEP > 1) ? $clog2(PP_DEEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PP_DEEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [NUMBIT-1:0]    a_q, a_d;
  logic [BW-1:0]        b_q, b_d;

  // Booth digit recoding for the current triplet
  logic [CNT_W:0]       shamt;       // 2*cnt, bit offset of the digit
  logic [2:0]           triplet;
  logic [PP_WIDTH-1:0]  pp_mag;      // |digit| * A, at most 2A
  logic                 pp_neg;
  logic [PW-1:0]        pp_ext;      // signed partial product, two's complement
  logic [PW-1:0]        pp_sh;       // weighted by 4^cnt

  assign shamt   = {cnt_q, 1'b0};
  assign triplet = b_q[shamt +: 3];

  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    unique case (triplet)
      3'b001, 3'b010: pp_mag = PP_WIDTH'(a_q);
      3'b011:         pp_mag = PP_WIDTH'({a_q, 1'b0});
      3'b100: begin
        pp_mag = PP_WIDTH'({a_q, 1'b0});
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = PP_WIDTH'(a_q);
        pp_neg = 1'b1;
      end
      default: begin  // 000, 111 -> digit 0
        pp_mag = '0;
        pp_neg = 1'b0;
      end
    endcase
  end

  // Negative digits are folded in as two's complement; the sum wraps modulo
  // 2^PW, which still lands on the exact unsigned product because the true
  // result always fits in PW bits.
  always_comb begin
    pp_ext = PW'(pp_mag);
    if (pp_neg) pp_ext = PW'(0) - pp_ext;
    pp_sh  = pp_ext << shamt;
  end

  // Next-state / datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_i;
          // Implicit 0 below the LSB for the first triplet; two zero bits on
          // top make the operand unsigned and force the last digit to {0,+1}.
          b_d     = {2'b00, bus.b_i, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + pp_sh;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        // acc is deliberately left alone so product_o stays readable.
        if (bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.product_o = acc_q;

endmodule
